// File: rtl/jump_fetch_unit.sv
// Fetch-address generator. It handles sequential advance, the two flavours of jump-register,
// and taken branches. A forwarded JR may wait in JR_WAIT for up to WAIT_MAX cycles.
module jump_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          WAIT_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_in,
  input  logic [1:0]  jump,
  input  logic        branch,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc4,
  input  logic [31:0] branch_offset,
  input  logic [31:0] rs_value,
  input  logic [31:0] fwd_value,
  input  logic        fwd_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        flush,
  output logic        jr_stall,
  output logic        misalign
);

  typedef enum logic {
    RUN     = 1'b0,
    JR_WAIT = 1'b1
  } state_e;

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_MAX - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic        flush_q, flush_d;
  logic        misalign_q, misalign_d;
  logic        redirect_s;
  logic        advance_s;
  logic [31:0] target_s;

  function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                input logic [31:0] off_words);
    return pc4 + (off_words << 2'd2);
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Next-state, redirect selection and output strobes; a stalled cycle changes nothing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    redirect_s = 1'b0;
    advance_s  = 1'b0;
    target_s   = pc_q;
    if (stall_in) begin
      state_d = state_q;
    end else begin
      case (state_q)
        RUN: begin
          case (jump)
            2'b01: begin
              redirect_s = 1'b1;
              target_s   = rs_value;
            end
            2'b10: begin
              if (fwd_valid) begin
                redirect_s = 1'b1;
                target_s   = fwd_value;
              end else begin
                state_d = JR_WAIT;
                cnt_d   = 3'd0;
              end
            end
            default: begin
              if (branch && branch_taken) begin
                redirect_s = 1'b1;
                target_s   = branch_target(branch_pc4, branch_offset);
              end else begin
                advance_s = 1'b1;
              end
            end
          endcase
        end
        JR_WAIT: begin
          // Forwarded data wins over a timeout that lands in the same cycle.
          if (fwd_valid) begin
            redirect_s = 1'b1;
            target_s   = fwd_value;
            state_d    = RUN;
          end else if (cnt_q == WAIT_LAST) begin
            redirect_s = 1'b1;
            target_s   = rs_value;
            state_d    = RUN;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = 3'd0;
        end
      endcase
    end

    if (redirect_s) begin
      pc_d = word_align(target_s);
    end else if (advance_s) begin
      pc_d = pc_q + 32'd4;
    end else begin
      pc_d = pc_q;
    end
    flush_d    = redirect_s;
    misalign_d = redirect_s && (target_s[1:0] != 2'b00);
  end

  // State, PC and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      cnt_q      <= 3'd0;
      pc_q       <= RESET_PC;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign flush    = flush_q;
  assign misalign = misalign_q;
  assign jr_stall = (state_q == JR_WAIT);

endmodule

// File: tb/tb_jump_fetch_unit.sv
// Directed bench for jump_fetch_unit (RESET_PC=0, WAIT_MAX=3).
// The bench drives inputs and checks outputs 1 time unit after each rising edge.
module tb_jump_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_in;
  logic [1:0]  jump;
  logic        branch;
  logic        branch_taken;
  logic [31:0] branch_pc4;
  logic [31:0] branch_offset;
  logic [31:0] rs_value;
  logic [31:0] fwd_value;
  logic        fwd_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        flush;
  logic        jr_stall;
  logic        misalign;

  int checks_cnt = 0;
  int fail_cnt   = 0;

  jump_fetch_unit #(.RESET_PC(32'h0000_0000), .WAIT_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .jump(jump),
    .branch(branch), .branch_taken(branch_taken), .branch_pc4(branch_pc4),
    .branch_offset(branch_offset), .rs_value(rs_value), .fwd_value(fwd_value),
    .fwd_valid(fwd_valid), .pc(pc), .pc_plus4(pc_plus4), .flush(flush),
    .jr_stall(jr_stall), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_in = 1'b0; jump = 2'b00; branch = 1'b0; branch_taken = 1'b0;
    fwd_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] epc, input logic efl,
                            input logic ejr, input logic emis);
    check_val({tag, ".pc"}, pc, epc);
    check_val({tag, ".flush"}, {31'd0, flush}, {31'd0, efl});
    check_val({tag, ".jr_stall"}, {31'd0, jr_stall}, {31'd0, ejr});
    check_val({tag, ".misalign"}, {31'd0, misalign}, {31'd0, emis});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    branch_pc4 = 32'd0; branch_offset = 32'd0; rs_value = 32'd0; fwd_value = 32'd0;
    #12;
    expect_out("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    expect_out("post_reset", 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("idle1", 32'h4, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("idle2", 32'h8, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("idle3", 32'hC, 1'b0, 1'b0, 1'b0);
    check_val("pc_plus4", pc_plus4, 32'h10);

    // JR without forwarding, first blocked by stall
    jump = 2'b01; rs_value = 32'h100; stall_in = 1'b1;
    tick(); expect_out("jr_stalled", 32'hC, 1'b0, 1'b0, 1'b0);
    stall_in = 1'b0;
    tick(); expect_out("jr01", 32'h100, 1'b1, 1'b0, 1'b0);
    idle_inputs();
    tick(); expect_out("jr01_after", 32'h104, 1'b0, 1'b0, 1'b0);

    // Back-to-back redirects: jump, branch, then jump+branch together
    jump = 2'b01; rs_value = 32'h500;
    tick(); expect_out("b2b_jump", 32'h500, 1'b1, 1'b0, 1'b0);
    jump = 2'b00; branch = 1'b1; branch_taken = 1'b1;
    branch_pc4 = 32'h40; branch_offset = 32'hFFFF_FFFC;
    tick(); expect_out("b2b_branch", 32'h30, 1'b1, 1'b0, 1'b0);
    jump = 2'b01; rs_value = 32'h600;
    tick(); expect_out("jump_over_branch", 32'h600, 1'b1, 1'b0, 1'b0);
    idle_inputs();
    tick(); expect_out("seq_after", 32'h604, 1'b0, 1'b0, 1'b0);
    branch = 1'b1; branch_taken = 1'b0;
    tick(); expect_out("branch_not_taken", 32'h608, 1'b0, 1'b0, 1'b0);
    idle_inputs(); jump = 2'b11; rs_value = 32'h900;
    tick(); expect_out("jump_reserved", 32'h60C, 1'b0, 1'b0, 1'b0);

    // JR with forwarding available immediately
    jump = 2'b10; fwd_valid = 1'b1; fwd_value = 32'h700;
    tick(); expect_out("jr10_fwd", 32'h700, 1'b1, 1'b0, 1'b0);

    // JR waiting, forward arrives on the 2nd JR_WAIT cycle
    fwd_valid = 1'b0; fwd_value = 32'h200;
    tick(); expect_out("wait_enter", 32'h700, 1'b0, 1'b1, 1'b0);
    jump = 2'b00;
    tick(); expect_out("wait_c2", 32'h700, 1'b0, 1'b1, 1'b0);
    fwd_valid = 1'b1;
    #1; check_val("wait_c2_fwd_jr", {31'd0, jr_stall}, 32'd1);
    tick(); expect_out("wait_fwd_load", 32'h200, 1'b1, 1'b0, 1'b0);
    fwd_valid = 1'b0;
    tick(); expect_out("wait_fwd_after", 32'h204, 1'b0, 1'b0, 1'b0);

    // JR timeout to rs_value, with a stall in the middle holding the counter
    jump = 2'b10; rs_value = 32'h300;
    tick(); expect_out("to_c1", 32'h204, 1'b0, 1'b1, 1'b0);
    jump = 2'b00;
    tick(); expect_out("to_c2", 32'h204, 1'b0, 1'b1, 1'b0);
    stall_in = 1'b1;
    tick(); expect_out("to_stalled", 32'h204, 1'b0, 1'b1, 1'b0);
    stall_in = 1'b0;
    tick(); expect_out("to_c3", 32'h204, 1'b0, 1'b1, 1'b0);
    tick(); expect_out("to_load", 32'h300, 1'b1, 1'b0, 1'b0);

    // Timeout and forward in the same cycle: forward wins
    jump = 2'b10; rs_value = 32'h800; fwd_value = 32'hA00;
    tick(); jump = 2'b00;
    tick(); tick();
    expect_out("tie_c3", 32'h300, 1'b0, 1'b1, 1'b0);
    fwd_valid = 1'b1;
    tick(); expect_out("tie_fwd", 32'hA00, 1'b1, 1'b0, 1'b0);
    idle_inputs();

    // Wrap at the top of the address space
    jump = 2'b01; rs_value = 32'hFFFF_FFFC;
    tick(); expect_out("wrap_load", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    check_val("wrap_plus4", pc_plus4, 32'h0);
    idle_inputs();
    tick(); expect_out("wrap", 32'h0, 1'b0, 1'b0, 1'b0);

    // Misaligned redirect target
    jump = 2'b01; rs_value = 32'h103;
    tick(); expect_out("misalign", 32'h100, 1'b1, 1'b0, 1'b1);
    idle_inputs();
    tick(); expect_out("misalign_after", 32'h104, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of JR_WAIT
    jump = 2'b10;
    tick(); expect_out("rst_wait", 32'h104, 1'b0, 1'b1, 1'b0);
    jump = 2'b00;
    #2 rst_n = 1'b0;
    #1 expect_out("rst_async", 32'h0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    tick(); expect_out("rst_first_edge", 32'h4, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/jump_fetch_unit.md
JUMP_FETCH_UNIT -- requirements
Module: jump_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 Parameter WAIT_MAX, default 3, SHALL be the maximum number of cycles spent in JR_WAIT before falling back to rs_value (range 1-7).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 stall_in  input  1  SHALL be the pipeline hazard freeze; high holds all state.
REQ-006 jump  input  2  SHALL be the decoder jump code: 00 none, 01 JR no forwarding, 10 JR with forwarding, 11 reserved.
REQ-007 branch  input  1  SHALL be the decoder branch flag.
REQ-008 branch_taken  input  1  SHALL be the branch condition result.
REQ-009 branch_pc4  input  32  SHALL be the PC+4 of the branch instruction.
REQ-010 branch_offset  input  32  SHALL be the sign-extended branch immediate in words.
REQ-011 rs_value  input  32  SHALL be the register-file read of rs.
REQ-012 fwd_value  input  32  SHALL be the forwarded EX-stage result.
REQ-013 fwd_valid  input  1  SHALL indicate that fwd_value is usable this cycle.
REQ-014 pc  output  32  SHALL be the registered fetch address.
REQ-015 pc_plus4  output  32  SHALL be pc+4, combinational, modulo 2^32.
REQ-016 flush  output  1  SHALL pulse to squash the wrong-path fetch.
REQ-017 jr_stall  output  1  SHALL request an upstream freeze while a forwarded JR target is pending.
REQ-018 misalign  output  1  SHALL pulse when a redirect target has bits[1:0] != 00.

Function
REQ-019 States SHALL be RUN and JR_WAIT, plus a wait counter of 3 bits.
REQ-020 In RUN with stall_in low and no redirect, pc SHALL advance to pc+4 each cycle; 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.
REQ-021 With stall_in high, pc, state and counter SHALL hold, and jump/branch inputs SHALL be ignored.
REQ-022 Redirect priority SHALL be jump over branch over sequential.
REQ-023 jump=01 SHALL load pc with rs_value on the next edge.
REQ-024 jump=10 with fwd_valid high SHALL load pc with fwd_value on the next edge.
REQ-025 jump=10 with fwd_valid low SHALL hold pc, enter JR_WAIT and clear the counter.
REQ-026 jump=11 SHALL be treated as 00.
REQ-027 branch and branch_taken both high with jump=00 SHALL load pc with branch_pc4 + (branch_offset<<2), truncated to 32 bits.
REQ-028 branch high with branch_taken low SHALL be sequential advance.
REQ-029 In JR_WAIT, jr_stall SHALL be 1 (combinational from state), pc SHALL hold, and the counter SHALL increment each unstalled cycle.
REQ-030 In JR_WAIT, fwd_valid high SHALL load pc with fwd_value and return to RUN.
REQ-031 In JR_WAIT, if the counter reaches WAIT_MAX-1 with fwd_valid still low, the next edge SHALL load pc with rs_value and return to RUN.
REQ-032 In JR_WAIT, fwd_valid and timeout in the same cycle SHALL select fwd_value.
REQ-033 flush SHALL be registered and high for exactly the one cycle in which a redirected pc first appears; sequential advance SHALL never assert flush.
REQ-034 Any redirect target with bits[1:0] != 00 SHALL load pc with bits[1:0] forced to 00, and misalign SHALL pulse in the same cycle as flush.
REQ-035 Back-to-back redirects on consecutive cycles SHALL each take effect, with flush high in both cycles.

Reset
REQ-036 rst_n low SHALL immediately force pc=RESET_PC, state=RUN, counter=0, flush=0, misalign=0 and jr_stall=0, including mid-JR_WAIT.
REQ-037 After rst_n deasserts, the first rising edge SHALL advance pc to RESET_PC+4.

Verification
REQ-038 Reset, then 3 idle cycles -> pc = 0, 4, 8, 12; flush=0 throughout.
REQ-039 jump=01, rs_value=32'h0000_0100 -> next pc=32'h100 with a 1-cycle flush; stall_in high on the same cycle -> pc holds and there is no flush.
REQ-040 jump=10, fwd_valid=0, then fwd_valid=1 with fwd_value=32'h200 on the 2nd cycle -> jr_stall high 2 cycles, pc=32'h200, flush once.
REQ-041 jump=10, fwd_valid held 0, rs_value=32'h300, WAIT_MAX=3 -> jr_stall high 3 cycles, then pc=32'h300.
REQ-042 branch=1, branch_taken=1, branch_pc4=32'h40, branch_offset=-4 -> pc=32'h30; with jump=01 in the same cycle -> the jump target wins.
REQ-043 rs_value=32'h0000_0103 on JR -> pc=32'h100, misalign and flush pulse together; rst_n low mid-JR_WAIT -> pc=RESET_PC asynchronously and jr_stall=0.
